// File: rtl/scorecard_keeper.sv
// scorecard_keeper: two-player Yacht scorecard with checked commits, serial total/bonus
// recomputation, game-over/winner detection and a registered random-read port.
module scorecard_keeper #(
    parameter int NUM_CAT      = 12,
    parameter int UPPER_CAT    = 6,
    parameter int BONUS_THRESH = 63,
    parameter int BONUS_VAL    = 35
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               commit,
    input  logic               commit_player,
    input  logic [3:0]         commit_cat,
    input  logic [7:0]         commit_score,
    output logic               busy,
    output logic               commit_ack,
    output logic               commit_rej,
    output logic [8:0]         p1_total,
    output logic [8:0]         p2_total,
    output logic               p1_bonus,
    output logic               p2_bonus,
    output logic [NUM_CAT-1:0] used_p1,
    output logic [NUM_CAT-1:0] used_p2,
    output logic               game_over,
    output logic [1:0]         winner,
    input  logic               rd_player,
    input  logic [3:0]         rd_cat,
    output logic [7:0]         rd_score,
    output logic               rd_used
);
    localparam logic [3:0]  NC   = 4'(NUM_CAT);
    localparam logic [3:0]  LAST = 4'(NUM_CAT - 1);
    localparam logic [3:0]  UC   = 4'(UPPER_CAT);
    localparam logic [8:0]  THR  = 9'(BONUS_THRESH);
    localparam logic [10:0] BV   = 11'(BONUS_VAL);

    typedef enum logic [1:0] {IDLE, CHECK, SUM, FINAL} state_t;
    state_t state, state_nx;

    logic               rst;
    logic               pl;
    logic [3:0]         cat;
    logic [7:0]         sc;
    logic [3:0]         idx;
    logic [7:0]         ent  [2][NUM_CAT];
    logic [NUM_CAT-1:0] used [2];
    logic [9:0]         acc  [2];
    logic [8:0]         up   [2];
    logic               bon  [2];
    logic [10:0]        tot_add [2];
    logic [8:0]         tot  [2];
    logic               reject;
    logic               go_nx;

    assign rst     = !reset_n || clear;
    assign used_p1 = used[0];
    assign used_p2 = used[1];
    // cat is range-checked first so an out-of-range used lookup never decides the outcome
    assign reject  = (cat >= NC) || used[pl][cat] || game_over;
    assign go_nx   = (&used[0]) && (&used[1]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (commit ? CHECK : IDLE) :
                   state == CHECK ? (reject ? IDLE : SUM) :
                   state == SUM   ? (idx == LAST ? FINAL : SUM) : IDLE;
    end

    always_comb begin
        busy = state != IDLE;
        for (int p = 0; p < 2; p++) begin
            bon[p]     = up[p] >= THR;
            tot_add[p] = {1'b0, acc[p]} + (bon[p] ? BV : 11'd0);
            tot[p]     = tot_add[p] > 11'd511 ? 9'd511 : tot_add[p][8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pl         <= 1'b0;
            cat        <= '0;
            sc         <= '0;
            idx        <= '0;
            commit_ack <= 1'b0;
            commit_rej <= 1'b0;
            p1_total   <= '0;
            p2_total   <= '0;
            p1_bonus   <= 1'b0;
            p2_bonus   <= 1'b0;
            game_over  <= 1'b0;
            winner     <= '0;
            rd_score   <= '0;
            rd_used    <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                used[p] <= '0;
                acc[p]  <= '0;
                up[p]   <= '0;
                for (int c = 0; c < NUM_CAT; c++) ent[p][c] <= '0;
            end
        end else begin
            commit_ack <= state == CHECK && !reject;
            commit_rej <= state == CHECK && reject;
            if (state == IDLE && commit) begin
                pl  <= commit_player;
                cat <= commit_cat;
                sc  <= commit_score;
            end
            if (state == CHECK && !reject) begin
                ent[pl][cat]  <= sc;
                used[pl][cat] <= 1'b1;
                idx           <= '0;
                for (int p = 0; p < 2; p++) begin
                    acc[p] <= '0;
                    up[p]  <= '0;
                end
            end
            if (state == SUM) begin
                idx <= idx + 4'd1;
                for (int p = 0; p < 2; p++) begin
                    acc[p] <= acc[p] + {2'b0, ent[p][idx]};
                    up[p]  <= idx < UC ? up[p] + {1'b0, ent[p][idx]} : up[p];
                end
            end
            if (state == FINAL) begin
                p1_total  <= tot[0];
                p2_total  <= tot[1];
                p1_bonus  <= bon[0];
                p2_bonus  <= bon[1];
                game_over <= go_nx;
                winner    <= !go_nx ? 2'd0 : tot[0] > tot[1] ? 2'd1 : tot[1] > tot[0] ? 2'd2 : 2'd3;
            end
            rd_score <= rd_cat < NC ? ent[rd_player][rd_cat] : 8'd0;
            rd_used  <= rd_cat < NC ? used[rd_player][rd_cat] : 1'b0;
        end
    end
endmodule
